calc_div_sched: RTL

- Shares one iterative restoring divider between two requesters in the MAX30102 calc path.
- Requester 0 is heart-rate BPM (60000 / period_ms); requester 1 is SpO2 ratio scaling.
- Round-robin arbitration, valid/ready request handshake, one-cycle result pulse per requester.
- Sits between the beat-interval / ratio capture logic and the BPM/SpO2 averaging stages. It replaces per-block repeated-subtraction loops with a fixed-latency shared unit.

---
 rtl/calc_pkg.sv | 19 +
 rtl/seq_divider.sv | 75 +++++++
 rtl/calc_div_sched.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/calc_pkg.sv
// -----------------------------------------------------------------------------
// calc_pkg
// Shared definitions for the MAX30102 calc-path divider scheduler.
//   state_t      : scheduler FSM encoding (IDLE=0, CALC=1, DONE=2)
//   CALC_DIV_W   : default operand/result width of the shared divider
//   BPM_DIVIDEND : ms-per-minute constant used by the heart-rate requester
// -----------------------------------------------------------------------------
package calc_pkg;

  localparam int CALC_DIV_W   = 17;
  localparam int BPM_DIVIDEND = 60000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/seq_divider.sv
// -----------------------------------------------------------------------------
// seq_divider
// Iterative restoring divider, one quotient bit per clock, MSB first.
// Ports:
//   clk, rst_n       : clock, asynchronous active-low reset
//   start            : load operands and begin (caller guarantees divisor != 0
//                      and that the unit is not already running)
//   dividend,divisor : operands, sampled only when start is high
//   done             : high during the cycle whose clock edge performs the
//                      final step; quot/rem are valid after that edge
//   quot, rem        : result, stable until the next start
// -----------------------------------------------------------------------------
module seq_divider
  import calc_pkg::*;
#(
  parameter int DIV_W = CALC_DIV_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [DIV_W-1:0] dividend,
  input  logic [DIV_W-1:0] divisor,
  output logic             done,
  output logic [DIV_W-1:0] quot,
  output logic [DIV_W-1:0] rem
);

  localparam int ITER_W = $clog2(DIV_W);

  logic              running;
  logic [ITER_W-1:0] iter_cnt;
  // Shift register: dividend bits leave at the MSB, quotient bits enter at
  // the LSB, so after DIV_W steps it holds the quotient.
  logic [DIV_W-1:0]  q_sh;
  logic [DIV_W:0]    rem_acc;
  logic [DIV_W-1:0]  div_reg;

  logic [DIV_W+1:0]  shifted;
  logic [DIV_W+1:0]  trial;
  logic              q_bit;

  // The extra top bit of trial acts as the borrow/sign of the subtraction.
  assign shifted = {rem_acc, q_sh[DIV_W-1]};
  assign trial   = shifted - {2'b00, div_reg};
  assign q_bit   = ~trial[DIV_W+1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      running  <= 1'b0;
      iter_cnt <= '0;
      q_sh     <= '0;
      rem_acc  <= '0;
      div_reg  <= '0;
    end else if (start) begin
      running  <= 1'b1;
      iter_cnt <= ITER_W'(DIV_W - 1);
      q_sh     <= dividend;
      rem_acc  <= '0;
      div_reg  <= divisor;
    end else if (running) begin
      rem_acc <= q_bit ? trial[DIV_W:0] : shifted[DIV_W:0];
      q_sh    <= {q_sh[DIV_W-2:0], q_bit};
      if (iter_cnt == '0) begin
        running <= 1'b0;
      end else begin
        iter_cnt <= iter_cnt - 1'b1;
      end
    end
  end

  assign done = running && (iter_cnt == '0);
  assign quot = q_sh;
  assign rem  = rem_acc[DIV_W-1:0];

endmodule

// File: rtl/calc_div_sched.sv
// -----------------------------------------------------------------------------
// calc_div_sched
// Shares one seq_divider between requester 0 (heart-rate BPM, 60000/period_ms)
// and requester 1 (SpO2 ratio scaling) with round-robin arbitration.
//
// Handshake: a request transfers on a rising edge where reqN_valid and
// reqN_ready are both high. The requester keeps valid and operands stable
// until it sees ready; dropping valid earlier simply cancels the request.
// reqN_ready is combinational from the valids and the FSM state: it is high
// only in IDLE and only for the requester chosen by the arbiter. Results
// are announced by a one-cycle resN_valid pulse; resN_quot/rem/err hold
// their values until that requester's next pulse.
//
// Ports:
//   clk, rst_n                         : clock, async active-low reset
//   reqN_valid/dividend/divisor/ready  : request channel of requester N
//   resN_valid/quot/rem/err            : result channel of requester N
//                                        (err = divide by zero; quot all ones,
//                                        rem = dividend in that case)
//   busy                               : FSM is not in IDLE
//   dbg_state                          : current FSM state (calc_pkg::state_t)
// -----------------------------------------------------------------------------
module calc_div_sched
  import calc_pkg::*;
#(
  parameter int DIV_W = CALC_DIV_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  input  logic [DIV_W-1:0] req0_dividend,
  input  logic [DIV_W-1:0] req0_divisor,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [DIV_W-1:0] req1_dividend,
  input  logic [DIV_W-1:0] req1_divisor,
  output logic             req1_ready,
  output logic             res0_valid,
  output logic [DIV_W-1:0] res0_quot,
  output logic [DIV_W-1:0] res0_rem,
  output logic             res0_err,
  output logic             res1_valid,
  output logic [DIV_W-1:0] res1_quot,
  output logic [DIV_W-1:0] res1_rem,
  output logic             res1_err,
  output logic             busy,
  output logic [1:0]       dbg_state
);

  state_t           state, state_nxt;
  logic             owner;       // requester whose op is in flight
  logic             last_grant;  // requester granted most recently
  logic             zero_op;     // op in flight is a divide by zero
  logic [DIV_W-1:0] zero_rem;    // dividend kept for the divide-by-zero result

  logic             grant0, grant1;
  logic             accept;
  logic [DIV_W-1:0] sel_dividend, sel_divisor;
  logic             sel_zero;

  logic             div_start, div_done;
  logic [DIV_W-1:0] div_quot, div_rem;

  logic [DIV_W-1:0] fin_quot, fin_rem;
  logic             fin_err;

  // Round-robin: a lone requester always wins; on a tie the requester that
  // was not granted last time wins. Reset leaves last_grant=1 so requester 0
  // takes the first tie.
  assign grant0 = req0_valid && (!req1_valid || last_grant);
  assign grant1 = req1_valid && (!req0_valid || !last_grant);

  assign req0_ready = (state == ST_IDLE) && grant0;
  assign req1_ready = (state == ST_IDLE) && grant1;
  assign accept     = req0_ready || req1_ready;

  assign sel_dividend = grant1 ? req1_dividend : req0_dividend;
  assign sel_divisor  = grant1 ? req1_divisor  : req0_divisor;
  assign sel_zero     = (sel_divisor == '0);

  // Divide by zero never reaches the divider; it goes straight to DONE.
  assign div_start = accept && !sel_zero;

  seq_divider #(
    .DIV_W (DIV_W)
  ) u_div (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (div_start),
    .dividend (sel_dividend),
    .divisor  (sel_divisor),
    .done     (div_done),
    .quot     (div_quot),
    .rem      (div_rem)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (accept) state_nxt = sel_zero ? ST_DONE : ST_CALC;
      ST_CALC: if (div_done) state_nxt = ST_DONE;
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner      <= 1'b0;
      last_grant <= 1'b1;
      zero_op    <= 1'b0;
      zero_rem   <= '0;
    end else if (accept) begin
      owner      <= grant1;
      last_grant <= grant1;
      zero_op    <= sel_zero;
      zero_rem   <= sel_dividend;
    end
  end

  assign fin_quot = zero_op ? {DIV_W{1'b1}} : div_quot;
  assign fin_rem  = zero_op ? zero_rem      : div_rem;
  assign fin_err  = zero_op;

  // Result registers load on the edge that leaves DONE, so the valid pulse
  // is seen in the first IDLE cycle; the other requester's set is untouched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res0_valid <= 1'b0;
      res0_quot  <= '0;
      res0_rem   <= '0;
      res0_err   <= 1'b0;
      res1_valid <= 1'b0;
      res1_quot  <= '0;
      res1_rem   <= '0;
      res1_err   <= 1'b0;
    end else begin
      res0_valid <= 1'b0;
      res1_valid <= 1'b0;
      if (state == ST_DONE) begin
        if (!owner) begin
          res0_valid <= 1'b1;
          res0_quot  <= fin_quot;
          res0_rem   <= fin_rem;
          res0_err   <= fin_err;
        end else begin
          res1_valid <= 1'b1;
          res1_quot  <= fin_quot;
          res1_rem   <= fin_rem;
          res1_err   <= fin_err;
        end
      end
    end
  end

  assign busy      = (state != ST_IDLE);
  assign dbg_state = state;

endmodule
